// File: rtl/pc_flow_ctrl_if.sv
// pc_flow_ctrl_if -- bundle between the pipeline and the PC/flow controller.
//
// Pipeline -> controller (master drives):
//   ex_valid, ex_npcop[2:0], ex_zero, ex_pc/ex_imm/ex_aluout[31:0],
//   idex_memread, idex_rd/ifid_rs1/ifid_rs2[4:0], imem_ready
// Controller -> pipeline (slave drives):
//   pc[31:0], fetch_req, ifid_stall, ifid_flush, idex_flush
//
// The master side is the pipeline/memory environment; the slave side is
// the controller. Clock and reset are plain ports on the controller.
interface pc_flow_ctrl_if;
  logic        ex_valid;
  logic [2:0]  ex_npcop;
  logic        ex_zero;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_aluout;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        imem_ready;
  logic [31:0] pc;
  logic        fetch_req;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;

  modport master (
    output ex_valid, ex_npcop, ex_zero, ex_pc, ex_imm, ex_aluout,
           idex_memread, idex_rd, ifid_rs1, ifid_rs2, imem_ready,
    input  pc, fetch_req, ifid_stall, ifid_flush, idex_flush
  );

  modport slave (
    input  ex_valid, ex_npcop, ex_zero, ex_pc, ex_imm, ex_aluout,
           idex_memread, idex_rd, ifid_rs1, ifid_rs2, imem_ready,
    output pc, fetch_req, ifid_stall, ifid_flush, idex_flush
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl -- program counter and pipeline flow controller.
//
// Owns the fetch PC and decides, every cycle, between a control-flow
// redirect from EX, waiting on instruction memory, a one-cycle load-use
// bubble, or sequential fetch (pc+4). Priority: redirect > fetch wait >
// load-use.
//
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset (pc=RESET_PC, state BOOT)
//   bus   - pc_flow_ctrl_if.slave (EX/hazard/imem inputs, pc and
//           pipeline-register control outputs)
//   redirect_cnt, stall_cnt - 32-bit performance counters, present only
//           when the macro PC_PERF_CNT_EN is defined.
//
// pc and fetch_req are registered; ifid_stall/ifid_flush/idex_flush are
// combinational so a redirect or stall takes effect in the same cycle.
module pc_flow_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rstn,
  pc_flow_ctrl_if.slave      bus
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0]        redirect_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_req_q, fetch_req_d;
  logic        lu_hold_q, lu_hold_d;

  logic        redirect;
  logic [31:0] target;
  logic        load_use;
  logic        ifid_stall, ifid_flush, idex_flush;

  // JALR targets are always halfword aligned, so bit 0 of the ALU result
  // never reaches the PC.
  logic unused_aluout_lsb;
  assign unused_aluout_lsb = bus.ex_aluout[0];

  always_comb begin
    redirect = 1'b0;
    if (bus.ex_valid) begin
      redirect = (bus.ex_npcop == OP_JUMP) || (bus.ex_npcop == OP_JALR) ||
                 ((bus.ex_npcop == OP_BRANCH) && bus.ex_zero);
    end
    if (bus.ex_npcop == OP_JALR) target = {bus.ex_aluout[31:1], 1'b0};
    else                         target = bus.ex_pc + bus.ex_imm;
    load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
               ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lu_hold_d  = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d       = target;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (!bus.imem_ready) begin
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          state_d    = ST_WAIT;
        end else if (load_use && !lu_hold_q) begin
          // lu_hold_q limits the bubble to one cycle even if the hazard
          // inputs do not change on the following cycle.
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          lu_hold_d  = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          // The word in flight belongs to the old path; flush it.
          pc_d       = target;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (bus.imem_ready) state_d = ST_RUN;
        end else begin
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          if (bus.imem_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_PC;
      end
    endcase
    fetch_req_d = (state_d != ST_BOOT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      lu_hold_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_req_q <= fetch_req_d;
      lu_hold_q   <= lu_hold_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.fetch_req  = fetch_req_q;
  assign bus.ifid_stall = ifid_stall;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;

`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // A redirect is counted only when it is acted on (ifid_flush).
  always_comb begin
    redirect_cnt_d = redirect_cnt_q + {31'd0, ifid_flush};
    stall_cnt_d    = stall_cnt_q + {31'd0, ifid_stall};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: doc/pc_flow_ctrl.md
PC_FLOW_CTRL -- requirements
Module: pc_flow_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ex_valid  input  1  EX stage holds a real instruction.
REQ-005 SHALL have port ex_npcop  input  3  EX next-PC op: 000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR; other codes act as PLUS4.
REQ-006 SHALL have port ex_zero  input  1  branch condition from ALU.
REQ-007 SHALL have ports ex_pc, ex_imm, ex_aluout  input  32 each  EX PC, immediate, ALU result.
REQ-008 SHALL have port idex_memread  input  1  EX instruction is a load.
REQ-009 SHALL have ports idex_rd, ifid_rs1, ifid_rs2  input  5 each  hazard register indices.
REQ-010 SHALL have port imem_ready  input  1  instruction memory returns data this cycle.
REQ-011 SHALL have port pc  output  32  current fetch address (registered).
REQ-012 SHALL have port fetch_req  output  1  fetch request to instruction memory.
REQ-013 SHALL have ports ifid_stall, ifid_flush, idex_flush  output  1 each  pipeline-register controls.

Function
REQ-014 SHALL implement states BOOT, RUN, WAIT.
REQ-015 BOOT: fetch_req=0, pc held; next state RUN unconditionally.
REQ-016 Redirect SHALL be ex_valid and (JUMP, or JALR, or BRANCH with ex_zero=1).
REQ-017 Target: ex_pc+ex_imm for BRANCH/JUMP; {ex_aluout[31:1],1'b0} for JALR; 32-bit add, carry-out discarded (wrap-around).
REQ-018 Load-use hazard SHALL be idex_memread and idex_rd!=0 and (idex_rd==ifid_rs1 or idex_rd==ifid_rs2).
REQ-019 Priority in RUN and WAIT: redirect > fetch wait > load-use.
REQ-020 Redirect: pc<=target next edge, ifid_flush=1, idex_flush=1, ifid_stall=0, same cycle (combinational); state unchanged.
REQ-021 RUN with imem_ready=0 and no redirect: pc held, ifid_stall=1, idex_flush=1, next state WAIT.
REQ-022 RUN with load-use and imem_ready=1: pc held, ifid_stall=1, idex_flush=1 for exactly one cycle.
REQ-023 RUN, no event: pc<=pc+4, all control outputs 0.
REQ-024 WAIT: fetch_req=1, pc held, ifid_stall=1, idex_flush=1; on imem_ready=1 pc<=pc+4 and return to RUN.
REQ-025 Redirect during WAIT SHALL load target, stay WAIT while imem_ready=0; returned data is discarded via ifid_flush.
REQ-026 fetch_req SHALL be 1 in RUN and WAIT.
REQ-027 ex_valid=0 SHALL suppress redirect regardless of ex_npcop.

Reset
REQ-028 rstn=0 SHALL immediately force pc=RESET_PC, state=BOOT, fetch_req=0, all flush/stall=0.
REQ-029 Reset asserted mid-redirect or mid-WAIT SHALL abandon the operation; no pending state survives.
REQ-030 First fetch SHALL occur the cycle after BOOT, at RESET_PC.

Configuration
REQ-031 Macro PC_PERF_CNT_EN defined: outputs redirect_cnt[31:0] and stall_cnt[31:0] present; redirect_cnt increments per redirect cycle, stall_cnt per cycle with ifid_stall=1; both reset to 0, wrap at 2^32.
REQ-032 Macro PC_PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-033 Reset release, imem_ready=1: pc sequence 0,0(BOOT),4,8,12; fetch_req 0 then 1.
REQ-034 ex_pc=0x100, ex_imm=0xFFFFFFF0, npcop=001, zero=1: next pc=0xF0, ifid_flush=idex_flush=1; zero=0 -> pc+4, no flush.
REQ-035 npcop=100, ex_aluout=0x203: next pc=0x202; same with ex_valid=0 -> no redirect.
REQ-036 idex_memread=1, idex_rd=5, ifid_rs2=5: one cycle ifid_stall=1, idex_flush=1, pc held; idex_rd=0 -> no stall.
REQ-037 imem_ready low 3 cycles, JUMP redirect in 2nd: state WAIT, pc=target, resumes pc=target+4 after ready; rstn pulse mid-WAIT -> pc=RESET_PC, BOOT.
REQ-038 With PC_PERF_CNT_EN: 2 redirects, 3 stall cycles -> redirect_cnt=2, stall_cnt=3.
